// File: rtl/tbird_monitor.sv
// Tail-light sequence monitor: tracks left/right/hazard lamp patterns, flags
// illegal transitions and keeps saturating counts of completed sequences and errors.
module tbird_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       y,
    output logic [1:0]       mode,
    output logic [1:0]       phase,
    output logic             seq_done,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HAZ  = 3'd7
    } state_t;

    localparam logic [5:0] Y_DARK = 6'b000000;
    localparam logic [5:0] Y_L1   = 6'b001000;
    localparam logic [5:0] Y_L2   = 6'b011000;
    localparam logic [5:0] Y_L3   = 6'b111000;
    localparam logic [5:0] Y_R1   = 6'b000100;
    localparam logic [5:0] Y_R2   = 6'b000110;
    localparam logic [5:0] Y_R3   = 6'b000111;
    localparam logic [5:0] Y_HAZ  = 6'b111111;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state_r;
    state_t     next_state_s;
    logic       done_s;
    logic       err_s;
    logic [1:0] mode_s;
    logic [1:0] phase_s;

    // Sequence entry decode, shared by IDLE and by resync after an error.
    function automatic state_t entry_state(input logic [5:0] yv);
        case (yv)
            Y_L1:    entry_state = L1;
            Y_R1:    entry_state = R1;
            Y_HAZ:   entry_state = HAZ;
            default: entry_state = IDLE;
        endcase
    endfunction

    // Next-state decode with error and completion detection.
    always_comb begin
        next_state_s = entry_state(y);
        done_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (y != Y_DARK && entry_state(y) == IDLE) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end
            L1: begin
                if (y == Y_L2) next_state_s = L2;
                else           err_s = 1'b1;
            end
            L2: begin
                if (y == Y_L3) next_state_s = L3;
                else           err_s = 1'b1;
            end
            R1: begin
                if (y == Y_R2) next_state_s = R2;
                else           err_s = 1'b1;
            end
            R2: begin
                if (y == Y_R3) next_state_s = R3;
                else           err_s = 1'b1;
            end
            L3, R3, HAZ: begin
                // Only a return to dark completes; anything else resyncs.
                if (y == Y_DARK) done_s = 1'b1;
                else             err_s  = 1'b1;
            end
            default: begin
                next_state_s = IDLE;
                err_s        = 1'b1;
            end
        endcase
    end

    // Map the state being entered to its mode/phase encoding.
    always_comb begin
        mode_s  = 2'd0;
        phase_s = 2'd0;
        case (next_state_s)
            L1:      begin mode_s = 2'd1; phase_s = 2'd1; end
            L2:      begin mode_s = 2'd1; phase_s = 2'd2; end
            L3:      begin mode_s = 2'd1; phase_s = 2'd3; end
            R1:      begin mode_s = 2'd2; phase_s = 2'd1; end
            R2:      begin mode_s = 2'd2; phase_s = 2'd2; end
            R3:      begin mode_s = 2'd2; phase_s = 2'd3; end
            HAZ:     begin mode_s = 2'd3; phase_s = 2'd0; end
            default: begin mode_s = 2'd0; phase_s = 2'd0; end
        endcase
    end

    // State register and registered outputs with saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            mode       <= 2'd0;
            phase      <= 2'd0;
            seq_done   <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            done_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            state_r    <= next_state_s;
            mode       <= mode_s;
            phase      <= phase_s;
            seq_done   <= done_s;
            err        <= err_s;
            err_sticky <= err_sticky | err_s;
            if (done_s && done_cnt != CNT_MAX) done_cnt <= done_cnt + CNT_ONE;
            else                               done_cnt <= done_cnt;
            if (err_s && err_cnt != CNT_MAX)   err_cnt  <= err_cnt + CNT_ONE;
            else                               err_cnt  <= err_cnt;
        end
    end

endmodule

// File: tb/tb_tbird_monitor.sv
// Directed bench for tbird_monitor: vector table on a default-width instance,
// plus counter saturation and mid-sequence reset on a CNT_W=2 instance.
module tb_tbird_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] y = 6'b000000;

    logic [1:0] mode, phase;
    logic       seq_done, err, err_sticky;
    logic [7:0] done_cnt, err_cnt;

    logic [1:0] mode2, phase2;
    logic       seq_done2, err2, err_sticky2;
    logic [1:0] done_cnt2, err_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tbird_monitor dut (
        .clk(clk), .reset(reset), .y(y),
        .mode(mode), .phase(phase), .seq_done(seq_done), .err(err),
        .err_sticky(err_sticky), .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    tbird_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .y(y),
        .mode(mode2), .phase(phase2), .seq_done(seq_done2), .err(err2),
        .err_sticky(err_sticky2), .done_cnt(done_cnt2), .err_cnt(err_cnt2)
    );

    typedef struct {
        logic       rst;
        logic [5:0] yv;
        logic [1:0] m;
        logic [1:0] p;
        logic       d;
        logic       e;
        logic       s;
        logic [7:0] dc;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] yv, input logic [1:0] m,
                       input logic [1:0] p, input logic d, input logic e,
                       input logic s, input logic [7:0] dc, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.yv = yv; v.m = m; v.p = p; v.d = d; v.e = e; v.s = s;
        v.dc = dc; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [5:0] yv);
        @(negedge clk);
        reset = r;
        y = yv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        // reset (held two cycles, y ignored)
        add(1'b1, 6'b111111, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        add(1'b1, 6'b001000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        // left sequence
        add(1'b0, 6'b001000, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        add(1'b0, 6'b011000, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        add(1'b0, 6'b111000, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        // right then hazard
        add(1'b0, 6'b000100, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
        add(1'b0, 6'b000110, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
        add(1'b0, 6'b000111, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
        add(1'b0, 6'b111111, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0);
        // illegal jump L1 -> right-full, then dark gives no seq_done
        add(1'b0, 6'b001000, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0);
        add(1'b0, 6'b000111, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'd3, 8'd1);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd3, 8'd1);
        // resync from L2 into R1
        add(1'b0, 6'b001000, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd3, 8'd1);
        add(1'b0, 6'b011000, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd3, 8'd1);
        add(1'b0, 6'b000100, 2'd2, 2'd1, 1'b0, 1'b1, 1'b1, 8'd3, 8'd2);
        add(1'b0, 6'b000110, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 8'd3, 8'd2);
        add(1'b0, 6'b000111, 2'd2, 2'd3, 1'b0, 1'b0, 1'b1, 8'd3, 8'd2);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 8'd4, 8'd2);
        // hold L1, then premature dark from L1
        add(1'b0, 6'b001000, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd4, 8'd2);
        add(1'b0, 6'b001000, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 8'd4, 8'd3);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'd4, 8'd4);
        // garbage pattern from IDLE
        add(1'b0, 6'b010101, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'd4, 8'd5);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd4, 8'd5);
        // hazard held, resyncs into hazard
        add(1'b0, 6'b111111, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 8'd4, 8'd5);
        add(1'b0, 6'b111111, 2'd3, 2'd0, 1'b0, 1'b1, 1'b1, 8'd4, 8'd6);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 8'd5, 8'd6);
        // reset in L2, then first sample judged from IDLE
        add(1'b0, 6'b001000, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd5, 8'd6);
        add(1'b0, 6'b011000, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd5, 8'd6);
        add(1'b1, 6'b111000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        add(1'b0, 6'b111000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd1);
        add(1'b0, 6'b000000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].yv);
            check($sformatf("vec%0d", i),
                  {9'd0, mode, phase, seq_done, err, err_sticky, done_cnt, err_cnt},
                  {9'd0, vecs[i].m, vecs[i].p, vecs[i].d, vecs[i].e, vecs[i].s,
                   vecs[i].dc, vecs[i].ec});
        end

        // saturation: five left sequences, four errors
        step(1'b1, 6'b000000);
        step(1'b1, 6'b000000);
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 6'b001000);
            step(1'b0, 6'b011000);
            step(1'b0, 6'b111000);
            step(1'b0, 6'b000000);
        end
        check("sat_done_w2", {30'd0, done_cnt2}, 32'd3);
        check("sat_done_w8", {24'd0, done_cnt}, 32'd5);
        for (int n = 0; n < 4; n++) step(1'b0, 6'b010101);
        check("sat_err_w2", {30'd0, err_cnt2}, 32'd3);
        check("sat_err_w8", {24'd0, err_cnt}, 32'd4);
        check("sat_sticky_w2", {31'd0, err_sticky2}, 32'd1);

        // reset asserted while in L2 clears everything, no pulses
        step(1'b0, 6'b001000);
        step(1'b0, 6'b011000);
        check("pre_rst_l2", {28'd0, mode2, phase2}, {28'd0, 2'd1, 2'd2});
        step(1'b1, 6'b111000);
        check("rst_l2_all", {23'd0, mode2, phase2, seq_done2, err2, err_sticky2,
                             done_cnt2, err_cnt2}, 32'd0);
        step(1'b0, 6'b000000);
        check("post_rst_dark", {23'd0, mode2, phase2, seq_done2, err2, err_sticky2,
                                done_cnt2, err_cnt2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
